mem_stage: RTL and testbench

Memory-access stage between Execute and Writeback. Latches instructions handed over by Execute. For loads whose request was already accepted (addr_ok) upstream, it waits for the data-SRAM response, then aligns and extends the returned word. It also drops responses that belong to flushed instructions and drives the M→D forwarding/stall information.

---
 rtl/mem_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between Execute and Writeback.
// It holds one instruction, waits for its data-SRAM response when a load
// request is already in flight, aligns and extends load data, and skips
// responses that belong to flushed instructions.
module mem_stage #(
  parameter int DROP_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_en,
  input  logic        EM_valid,
  output logic        M_allowin,
  input  logic [31:0] em_pc,
  input  logic [31:0] em_alu_result,
  input  logic        em_gr_we,
  input  logic [4:0]  em_dest,
  input  logic [3:0]  em_res_from_mem,
  input  logic        em_req_sent,
  input  logic        em_ex,
  input  logic [7:0]  em_ecode,
  input  logic        em_esubcode,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        W_allowin,
  output logic        MW_valid,
  output logic [31:0] mw_pc,
  output logic [31:0] mw_rf_wdata,
  output logic        mw_gr_we,
  output logic [4:0]  mw_dest,
  output logic        mw_ex,
  output logic [7:0]  mw_ecode,
  output logic        mw_esubcode,
  output logic [4:0]  MD_for_dest,
  output logic [31:0] MD_for_wdata,
  output logic        MD_for_stall
);

  localparam logic [DROP_W:0] DROP_MAX = (DROP_W+1)'(2);

  logic              m_valid;
  logic              waiting;
  logic              buf_valid;
  logic [31:0]       rbuf;
  logic [DROP_W-1:0] drop_cnt;
  logic [31:0]       m_alu;
  logic [3:0]        m_rfm;

  logic              drop_zero;
  logic              ok_owned;
  logic              ok_stale;
  logic              m_ready_go;
  logic              accept;
  logic              handoff;
  logic              is_load;
  logic [31:0]       ld_src;
  logic [1:0]        off;
  logic [15:0]       half;
  logic [7:0]        byte_v;
  logic [31:0]       ld_val;
  logic              m_owes;
  logic              em_owes;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_flush;

  // A data_ok is ours only when no stale responses are still in front of it.
  assign drop_zero  = (drop_cnt == '0);
  assign ok_owned   = data_sram_data_ok && drop_zero;
  assign ok_stale   = data_sram_data_ok && !drop_zero;

  assign m_ready_go = !waiting || ok_owned;
  assign MW_valid   = m_valid && m_ready_go;
  assign M_allowin  = !m_valid || (m_ready_go && W_allowin);
  assign accept     = EM_valid && M_allowin;
  assign handoff    = MW_valid && W_allowin;

  // Load alignment: buffered data wins once captured under back-pressure.
  assign is_load = m_rfm[3] | m_rfm[1] | m_rfm[0];
  assign ld_src  = buf_valid ? rbuf : data_sram_rdata;
  assign off     = m_alu[1:0];
  assign half    = ld_src[{off[1], 4'b0000} +: 16];
  assign byte_v  = ld_src[{off, 3'b000} +: 8];

  // Select word / half / byte and extend (zero-extend when bit 2 set).
  always_comb begin
    ld_val = ld_src;
    if (m_rfm[3])      ld_val = ld_src;
    else if (m_rfm[1]) ld_val = {{16{~m_rfm[2] & half[15]}}, half};
    else if (m_rfm[0]) ld_val = {{24{~m_rfm[2] & byte_v[7]}}, byte_v};
  end

  assign mw_rf_wdata  = is_load ? ld_val : m_alu;
  assign MD_for_wdata = mw_rf_wdata;
  assign MD_for_dest  = (m_valid && mw_gr_we) ? mw_dest : 5'd0;
  assign MD_for_stall = m_valid && waiting && is_load && !ok_owned;

  // Responses orphaned by a flush: M's pending one (unless it lands this
  // very cycle) plus Execute's in-flight one, minus a stale one retiring now.
  assign m_owes  = m_valid && waiting && !ok_owned;
  assign em_owes = EM_valid && em_req_sent;

  always_comb begin
    drop_sum   = {1'b0, drop_cnt} + (DROP_W+1)'(m_owes) + (DROP_W+1)'(em_owes)
                 - (DROP_W+1)'(ok_stale);
    drop_flush = (drop_sum > DROP_MAX) ? DROP_MAX[DROP_W-1:0] : drop_sum[DROP_W-1:0];
  end

  // Stale-response counter: reloaded on flush, otherwise counts down per stale data_ok.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           drop_cnt <= '0;
    else if (ex_en)    drop_cnt <= drop_flush;
    else if (ok_stale) drop_cnt <= drop_cnt - 1'b1;
  end

  // Stage valid, response wait and back-pressure buffer; flush has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid   <= 1'b0;
      waiting   <= 1'b0;
      buf_valid <= 1'b0;
      rbuf      <= '0;
    end else if (ex_en) begin
      m_valid   <= 1'b0;
      waiting   <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      if (M_allowin) m_valid <= EM_valid;
      if (accept) begin
        waiting   <= em_req_sent && !em_ex;
        buf_valid <= 1'b0;
      end else begin
        if (waiting && ok_owned) waiting <= 1'b0;
        if (waiting && ok_owned && !W_allowin) begin
          rbuf      <= data_sram_rdata;
          buf_valid <= 1'b1;
        end else if (handoff) begin
          buf_valid <= 1'b0;
        end
      end
    end
  end

  // Instruction fields captured on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_pc       <= '0;
      m_alu       <= '0;
      mw_gr_we    <= 1'b0;
      mw_dest     <= '0;
      m_rfm       <= '0;
      mw_ex       <= 1'b0;
      mw_ecode    <= '0;
      mw_esubcode <= 1'b0;
    end else if (accept && !ex_en) begin
      mw_pc       <= em_pc;
      m_alu       <= em_alu_result;
      mw_gr_we    <= em_gr_we;
      mw_dest     <= em_dest;
      m_rfm       <= em_res_from_mem;
      mw_ex       <= em_ex;
      mw_ecode    <= em_ecode;
      mw_esubcode <= em_esubcode;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage.
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_en, EM_valid, M_allowin;
  logic [31:0] em_pc, em_alu_result;
  logic        em_gr_we;
  logic [4:0]  em_dest;
  logic [3:0]  em_res_from_mem;
  logic        em_req_sent, em_ex;
  logic [7:0]  em_ecode;
  logic        em_esubcode;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        W_allowin, MW_valid;
  logic [31:0] mw_pc, mw_rf_wdata;
  logic        mw_gr_we;
  logic [4:0]  mw_dest;
  logic        mw_ex;
  logic [7:0]  mw_ecode;
  logic        mw_esubcode;
  logic [4:0]  MD_for_dest;
  logic [31:0] MD_for_wdata;
  logic        MD_for_stall;

  always #5 clk = ~clk;

  mem_stage #(.DROP_W(2)) dut (
    .clk(clk), .rst(rst), .ex_en(ex_en), .EM_valid(EM_valid), .M_allowin(M_allowin),
    .em_pc(em_pc), .em_alu_result(em_alu_result), .em_gr_we(em_gr_we), .em_dest(em_dest),
    .em_res_from_mem(em_res_from_mem), .em_req_sent(em_req_sent), .em_ex(em_ex),
    .em_ecode(em_ecode), .em_esubcode(em_esubcode), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .W_allowin(W_allowin), .MW_valid(MW_valid),
    .mw_pc(mw_pc), .mw_rf_wdata(mw_rf_wdata), .mw_gr_we(mw_gr_we), .mw_dest(mw_dest),
    .mw_ex(mw_ex), .mw_ecode(mw_ecode), .mw_esubcode(mw_esubcode),
    .MD_for_dest(MD_for_dest), .MD_for_wdata(MD_for_wdata), .MD_for_stall(MD_for_stall)
  );

  typedef struct {
    logic [31:0] pc, alu, data;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  rfm;
    logic        req, ex;
    logic [7:0]  ecode;
    logic        esub;
  } instr_t;

  typedef struct {
    logic [31:0] pc, wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic        ex;
    logic [7:0]  ecode;
    logic        esub;
    logic        is_load;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    bit          stale;
  } resp_t;

  exp_t   exp_q[$];
  resp_t  resp_q[$];
  int     total = 0;
  int     bad = 0;
  bit     run = 0;
  bit     live_wait = 0;
  bit     em_hold = 0;
  int     n_issued = 0;
  instr_t cur_i;

  // expectations for the current cycle, fixed when inputs are driven
  bit   c_present, c_mwv, c_stall, c_allow;
  exp_t c_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: pick the addressed lane and extend it arithmetically.
  function automatic logic [31:0] ref_wdata(instr_t i);
    int unsigned off;
    logic [31:0] v;
    off = int'(i.alu[1:0]);
    case (i.rfm)
      4'b1000: v = i.data;
      4'b0010, 4'b0110: begin
        v = (i.data >> (16 * (off / 2))) % 32'd65536;
        if (i.rfm == 4'b0010 && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      4'b0001, 4'b0101: begin
        v = (i.data >> (8 * off)) % 32'd256;
        if (i.rfm == 4'b0001 && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      default: v = i.alu;
    endcase
    return v;
  endfunction

  function automatic exp_t mk_exp(instr_t i);
    exp_t e;
    e.pc = i.pc; e.wdata = ref_wdata(i); e.gr_we = i.gr_we; e.dest = i.dest;
    e.ex = i.ex; e.ecode = i.ecode; e.esub = i.esub; e.is_load = (i.rfm != 4'b0000);
    return e;
  endfunction

  function automatic instr_t gen(int k);
    instr_t i;
    int t;
    i.pc = $urandom; i.alu = $urandom; i.data = $urandom;
    i.gr_we = 1'($urandom); i.dest = 5'($urandom); i.rfm = 4'b0000;
    i.req = 1'b0; i.ex = 1'b0; i.ecode = 8'($urandom); i.esub = 1'($urandom);
    case (k)
      0: begin i.alu = 32'h1234_5678; i.gr_we = 1'b1; i.dest = 5'd5; end
      1: begin i.alu = 32'h0000_1003; i.data = 32'h80FF_0011; i.rfm = 4'b0001; i.req = 1'b1; end
      2: begin i.alu = 32'h0000_2003; i.data = 32'h80FF_0011; i.rfm = 4'b0101; i.req = 1'b1; end
      3: begin i.alu = 32'h0000_3002; i.data = 32'h8001_7FFF; i.rfm = 4'b0010; i.req = 1'b1; end
      4: begin i.ex = 1'b1; i.ecode = 8'h09; end
      default: begin
        t = $urandom_range(0, 6);
        case (t)
          1: begin i.rfm = 4'b0001; i.req = 1'b1; end
          2: begin i.rfm = 4'b0101; i.req = 1'b1; end
          3: begin i.rfm = 4'b0010; i.req = 1'b1; i.alu[0] = 1'b0; end
          4: begin i.rfm = 4'b0110; i.req = 1'b1; i.alu[0] = 1'b0; end
          5: begin i.rfm = 4'b1000; i.req = 1'b1; i.alu[1:0] = 2'b00; end
          6: i.ex = 1'b1;
          default: ;
        endcase
      end
    endcase
    return i;
  endfunction

  // Drive one cycle of inputs (just after the rising edge) and fix expectations.
  task automatic drive(input bit issue_ok, input bit flush_ok);
    int    n_stale;
    bit    ok_owned;
    resp_t r;
    if (!em_hold && issue_ok && $urandom_range(0, 9) < 7) begin
      cur_i = gen(n_issued);
      n_issued++;
      em_hold = 1'b1;
    end
    EM_valid = em_hold;
    em_pc = cur_i.pc; em_alu_result = cur_i.alu; em_gr_we = cur_i.gr_we; em_dest = cur_i.dest;
    em_res_from_mem = cur_i.rfm; em_req_sent = cur_i.req; em_ex = cur_i.ex;
    em_ecode = cur_i.ecode; em_esubcode = cur_i.esub;

    n_stale = 0;
    foreach (resp_q[j]) if (resp_q[j].stale) n_stale++;
    ex_en = flush_ok && (n_stale == 0) && ($urandom_range(0, 24) == 0);
    W_allowin = ex_en ? 1'b0 : ($urandom_range(0, 9) < 7);

    ok_owned = 1'b0;
    if (resp_q.size() > 0 && $urandom_range(0, 9) < 4) begin
      r = resp_q.pop_front();
      data_sram_data_ok = 1'b1;
      data_sram_rdata = r.data;
      ok_owned = !r.stale;
    end else begin
      data_sram_data_ok = 1'b0;
      data_sram_rdata = $urandom;
    end

    c_present = (exp_q.size() > 0);
    if (c_present) c_exp = exp_q[0];
    c_mwv   = c_present && (!live_wait || ok_owned);
    c_stall = c_present && c_exp.is_load && live_wait && !ok_owned;
    c_allow = !c_present || (c_mwv && W_allowin);
    if (ok_owned) live_wait = 1'b0;
  endtask

  // Account for what the edge ending this cycle will do: flush or accept.
  task automatic update();
    if (ex_en) begin
      exp_q.delete();
      foreach (resp_q[j]) resp_q[j].stale = 1'b1;
      live_wait = 1'b0;
      if (EM_valid && em_req_sent) resp_q.push_back('{data: $urandom, stale: 1'b1});
      em_hold = 1'b0;
    end else if (EM_valid && c_allow) begin
      exp_q.push_back(mk_exp(cur_i));
      if (cur_i.req) begin
        resp_q.push_back('{data: cur_i.data, stale: 1'b0});
        live_wait = 1'b1;
      end
      em_hold = 1'b0;
    end
  endtask

  // Monitor: checks every cycle, retires scoreboard entries on handoff.
  always @(negedge clk) begin
    if (run) begin
      chk("mw_valid", 32'(MW_valid), 32'(c_mwv));
      chk("m_allowin", 32'(M_allowin), 32'(c_allow));
      chk("md_stall", 32'(MD_for_stall), 32'(c_stall));
      chk("md_dest", 32'(MD_for_dest),
          (c_present && c_exp.gr_we) ? 32'(c_exp.dest) : 32'd0);
      if (c_mwv) begin
        chk("mw_rf_wdata", mw_rf_wdata, c_exp.wdata);
        chk("md_wdata", MD_for_wdata, c_exp.wdata);
        chk("mw_pc", mw_pc, c_exp.pc);
        if (W_allowin) begin
          void'(exp_q.pop_front());
          chk("mw_gr_we", 32'(mw_gr_we), 32'(c_exp.gr_we));
          chk("mw_dest", 32'(mw_dest), 32'(c_exp.dest));
          chk("mw_ex", 32'(mw_ex), 32'(c_exp.ex));
          chk("mw_ecode", 32'(mw_ecode), 32'(c_exp.ecode));
          chk("mw_esub", 32'(mw_esubcode), 32'(c_exp.esub));
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; ex_en = 1'b0; EM_valid = 1'b0;
    em_pc = '0; em_alu_result = '0; em_gr_we = 1'b0; em_dest = '0; em_res_from_mem = '0;
    em_req_sent = 1'b0; em_ex = 1'b0; em_ecode = '0; em_esubcode = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; W_allowin = 1'b1;
    cur_i = gen(99);
    repeat (2) @(negedge clk);
    chk("rst_m_allowin", 32'(M_allowin), 32'd1);
    chk("rst_mw_valid", 32'(MW_valid), 32'd0);
    chk("rst_md_dest", 32'(MD_for_dest), 32'd0);
    chk("rst_md_stall", 32'(MD_for_stall), 32'd0);
    chk("rst_md_wdata", MD_for_wdata, 32'd0);
    chk("rst_mw_pc", mw_pc, 32'd0);
    chk("rst_mw_wdata", mw_rf_wdata, 32'd0);
    chk("rst_mw_ex", 32'(mw_ex), 32'd0);
    chk("rst_mw_ecode", 32'(mw_ecode), 32'd0);
    chk("rst_mw_gr_we", 32'(mw_gr_we), 32'd0);
    chk("rst_mw_dest", 32'(mw_dest), 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      drive(1'b1, 1'b1);
      run = 1'b1;
      @(negedge clk);
      update();
      @(posedge clk); #1;
    end
    n = 0;
    while ((exp_q.size() > 0 || resp_q.size() > 0 || em_hold) && n < 300) begin
      drive(1'b0, 1'b0);
      @(negedge clk);
      update();
      @(posedge clk); #1;
      n++;
    end
    run = 1'b0;
    chk("drain_pending", 32'(exp_q.size() + resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
